// File: rtl/cpu_mc.sv
// rtl/cpu_mc.sv - multicycle accumulator CPU core with req/ack memory port
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   mem_req_o     memory access request (forced low while rst_ni=0)
//   mem_we_o      1 = write, 0 = read; valid while mem_req_o=1
//   mem_addr_o    access address (PC on fetch, operand on execute)
//   mem_wdata_o   write data (accumulator)
//   mem_rdata_i   read data, sampled only in an ack cycle
//   mem_ack_i     access complete, ignored while mem_req_o=0
//   pc_o/ac_o/ir_o/z_o/c_o  architectural state
//   retire_o      one-cycle pulse after an instruction completes
//   halt_o        core halted
module cpu_mc #(
  parameter int DW       = 8,
  parameter int AW       = 5,
  parameter int RESET_PC = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic [AW-1:0] pc_o,
  output logic [DW-1:0] ac_o,
  output logic [DW-1:0] ir_o,
  output logic          z_o,
  output logic          c_o,
  output logic          retire_o,
  output logic          halt_o
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_e;

  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_STA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_JZ  = 3'd4;
  localparam logic [2:0] OP_JC  = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ac_q, ac_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          z_q, z_d;
  logic          c_q, c_d;
  logic          retire_q, retire_d;

  logic          req_c;
  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [2:0]    opcode;
  logic [AW-1:0] operand;
  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic          take;

  assign opcode  = ir_q[DW-1:DW-3];
  assign operand = ir_q[AW-1:0];

  // One extra bit carries out of the add and holds the borrow of the subtract.
  assign sum  = {1'b0, ac_q} + {1'b0, mem_rdata_i};
  assign diff = {1'b0, ac_q} - {1'b0, mem_rdata_i};

  assign take = (opcode == OP_JMP) ||
                ((opcode == OP_JZ) && z_q) ||
                ((opcode == OP_JC) && c_q);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ac_d     = ac_q;
    ir_d     = ir_q;
    z_d      = z_q;
    c_d      = c_q;
    retire_d = 1'b0;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = pc_q;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ack_i) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_JZ, OP_JC, OP_JMP: begin
            if (take) pc_d = operand;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          OP_HLT: begin
            retire_d = 1'b1;
            state_d  = S_HALT;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        req_c  = 1'b1;
        addr_c = operand;
        we_c   = (opcode == OP_STA);
        if (mem_ack_i) begin
          retire_d = 1'b1;
          state_d  = S_FETCH;
          case (opcode)
            OP_LDA: begin
              ac_d = mem_rdata_i;
              z_d  = (mem_rdata_i == '0);
            end
            OP_ADD: begin
              ac_d = sum[DW-1:0];
              c_d  = sum[DW];
              z_d  = (sum[DW-1:0] == '0);
            end
            OP_SUB: begin
              ac_d = diff[DW-1:0];
              c_d  = diff[DW];
              z_d  = (diff[DW-1:0] == '0);
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_FETCH;
      pc_q     <= AW'(RESET_PC);
      ac_q     <= '0;
      ir_q     <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ac_q     <= ac_d;
      ir_q     <= ir_d;
      z_q      <= z_d;
      c_q      <= c_d;
      retire_q <= retire_d;
    end
  end

  // Reset state is FETCH, which requests; gating with rst_ni keeps the
  // request low for the whole reset without waiting for a clock edge.
  assign mem_req_o   = req_c & rst_ni;
  assign mem_we_o    = we_c & rst_ni;
  assign mem_addr_o  = addr_c;
  assign mem_wdata_o = ac_q;

  assign pc_o     = pc_q;
  assign ac_o     = ac_q;
  assign ir_o     = ir_q;
  assign z_o      = z_q;
  assign c_o      = c_q;
  assign retire_o = retire_q;
  assign halt_o   = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_mc.sv
// tb/tb_cpu_mc.sv - self-checking bench for cpu_mc against an instruction-level model
module tb_cpu_mc;
  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          mem_ack_i;
  logic [AW-1:0] pc_o;
  logic [DW-1:0] ac_o, ir_o;
  logic          z_o, c_o, retire_o, halt_o;

  cpu_mc #(.DW(DW), .AW(AW), .RESET_PC(0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .pc_o(pc_o), .ac_o(ac_o), .ir_o(ir_o), .z_o(z_o), .c_o(c_o),
    .retire_o(retire_o), .halt_o(halt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // memory responder
  logic [DW-1:0] tb_mem [32];
  int wait_n = 0;
  int wcnt = 0;
  assign mem_ack_i   = mem_req_o && (wcnt == wait_n);
  assign mem_rdata_i = tb_mem[mem_addr_o];

  always @(posedge clk_i) begin
    if (!rst_ni) wcnt <= 0;
    else if (mem_req_o && !mem_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (rst_ni && mem_req_o && mem_ack_i && mem_we_o) tb_mem[mem_addr_o] = mem_wdata_o;
  end

  // instruction-level model
  logic [DW-1:0] m_mem [32];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_ac, m_ir;
  logic          m_z, m_c, m_halt;
  int            lat_exp;

  bit            chk_en = 1'b0;
  int            cyc, n_ret, we_cycles;
  logic [DW-1:0] snap_ac [16];
  logic [AW-1:0] snap_pc [16];
  logic          snap_z [16];
  logic          snap_c [16];
  int            snap_lat [16];

  logic          prev_req, prev_ack, prev_we;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic [22:0]   prev_regs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [DW-1:0] ins;
    logic [2:0]    op;
    logic [AW-1:0] a;
    int            sum;
    ins  = m_mem[m_pc];
    m_ir = ins;
    m_pc = m_pc + 1;
    op   = ins[7:5];
    a    = ins[4:0];
    lat_exp = 2 + wait_n;
    case (op)
      3'd0: begin m_ac = m_mem[a]; m_z = (m_ac == 0); lat_exp = 3 + 2 * wait_n; end
      3'd1: begin m_mem[a] = m_ac; lat_exp = 3 + 2 * wait_n; end
      3'd2: begin
        sum  = int'(m_ac) + int'(m_mem[a]);
        m_c  = (sum > 255);
        m_ac = 8'(sum % 256);
        m_z  = (m_ac == 0);
        lat_exp = 3 + 2 * wait_n;
      end
      3'd3: begin
        m_c  = (m_ac < m_mem[a]);
        sum  = int'(m_ac) - int'(m_mem[a]) + 256;
        m_ac = 8'(sum % 256);
        m_z  = (m_ac == 0);
        lat_exp = 3 + 2 * wait_n;
      end
      3'd4: if (m_z) m_pc = a;
      3'd5: if (m_c) m_pc = a;
      3'd6: m_pc = a;
      default: m_halt = 1'b1;
    endcase
  endtask

  always @(negedge clk_i) begin
    if (chk_en && rst_ni) begin
      cyc++;
      if (prev_req && !prev_ack) begin
        check("hold_req", mem_req_o, 1);
        check("hold_we", mem_we_o, prev_we);
        check("hold_addr", mem_addr_o, prev_addr);
        check("hold_wdata", mem_wdata_o, prev_wdata);
        check("hold_regs", {pc_o, ac_o, ir_o, z_o, c_o}, prev_regs);
      end
      if (retire_o) begin
        model_step();
        check("latency", cyc, lat_exp);
        check("pc", pc_o, m_pc);
        check("ac", ac_o, m_ac);
        check("ir", ir_o, m_ir);
        check("z", z_o, m_z);
        check("c", c_o, m_c);
        if (!m_halt) check("next_fetch", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, m_pc});
        if (n_ret < 16) begin
          snap_ac[n_ret] = ac_o; snap_pc[n_ret] = pc_o;
          snap_z[n_ret] = z_o; snap_c[n_ret] = c_o; snap_lat[n_ret] = cyc;
        end
        n_ret++;
        cyc = 0;
      end
      check("halt_o", halt_o, m_halt);
      if (m_halt) check("halt_req", mem_req_o, 0);
      if (mem_req_o && mem_we_o) we_cycles++;
      prev_req = mem_req_o; prev_ack = mem_ack_i; prev_we = mem_we_o;
      prev_addr = mem_addr_o; prev_wdata = mem_wdata_o;
      prev_regs = {pc_o, ac_o, ir_o, z_o, c_o};
    end
  end

  task automatic load(input int which);
    for (int i = 0; i < 32; i++) tb_mem[i] = 8'h00;
    if (which == 0) begin
      tb_mem[0] = 8'h0A; tb_mem[1] = 8'h4B; tb_mem[2] = 8'h94;
      tb_mem[20] = 8'h0C; tb_mem[21] = 8'h6D; tb_mem[22] = 8'h84;
      tb_mem[23] = 8'h2E; tb_mem[24] = 8'hBA; tb_mem[26] = 8'hE0;
      tb_mem[10] = 8'h7F; tb_mem[11] = 8'h81; tb_mem[12] = 8'h05; tb_mem[13] = 8'h07;
    end else begin
      tb_mem[0] = 8'hA8; tb_mem[1] = 8'h0A; tb_mem[2] = 8'h2C;
      tb_mem[3] = 8'h0B; tb_mem[4] = 8'h4B; tb_mem[5] = 8'hDF;
      tb_mem[31] = 8'h0A; tb_mem[8] = 8'hE0;
      tb_mem[10] = 8'h5A; tb_mem[11] = 8'hFF;
    end
    for (int i = 0; i < 32; i++) m_mem[i] = tb_mem[i];
  endtask

  // Called with rst_ni low; releases reset just after a negedge.
  task automatic start_run();
    @(negedge clk_i);
    #1;
    m_pc = '0; m_ac = '0; m_ir = '0; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
    cyc = 0; n_ret = 0; we_cycles = 0; prev_req = 1'b0; prev_ack = 1'b0;
    chk_en = 1'b1;
    rst_ni = 1'b1;
    #1;
    check("first_fetch", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 5'd0});
  endtask

  task automatic run_to_halt(input int budget);
    for (int i = 0; i < budget && !m_halt; i++) @(negedge clk_i);
    check("halt_reached", m_halt, 1);
    repeat (20) @(negedge clk_i);
    #1;
    chk_en = 1'b0;
  endtask

  task automatic enter_reset(input int w);
    chk_en = 1'b0;
    #2;
    rst_ni = 1'b0;
    wait_n = w;
    repeat (2) @(posedge clk_i);
  endtask

  initial begin
    load(0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_pc", pc_o, 0);
    check("rst_ac", ac_o, 0);
    check("rst_flags", {z_o, c_o}, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_halt", halt_o, 0);
    check("rst_retire", retire_o, 0);

    // program A: arithmetic, branches, store, zero wait
    start_run();
    run_to_halt(200);
    check("A_n_ret", n_ret, 9);
    check("A_lda_ac", snap_ac[0], 8'h7F);
    check("A_lda_z", snap_z[0], 0);
    check("A_add_ac", snap_ac[1], 8'h00);
    check("A_add_zc", {snap_z[1], snap_c[1]}, 2'b11);
    check("A_add_spacing", snap_lat[1], 3);
    check("A_jz_taken", snap_pc[2], 20);
    check("A_sub_ac", snap_ac[4], 8'hFE);
    check("A_sub_zc", {snap_z[4], snap_c[4]}, 2'b01);
    check("A_jz_not_taken", snap_pc[5], 23);
    check("A_sta_mem", tb_mem[14], 8'hFE);
    check("A_jc_taken", snap_pc[7], 26);
    check("A_halt_o", halt_o, 1);

    // program B: store, wrap, carry branch
    enter_reset(0);
    load(1);
    start_run();
    run_to_halt(200);
    check("B_jc_not_taken", snap_pc[0], 1);
    check("B_sta_mem", tb_mem[12], 8'h5A);
    check("B_write_cycles", we_cycles, 1);
    check("B_sta_flags", {snap_z[2], snap_c[2]}, 2'b00);
    check("B_add_c", snap_c[4], 1);
    check("B_wrap_pc", snap_pc[6], 0);
    check("B_jc_wrap", snap_pc[7], 8);

    // program A with 3 wait states on every access
    enter_reset(3);
    load(0);
    start_run();
    run_to_halt(600);
    check("W_lda_latency", snap_lat[0], 9);
    check("W_add_ac", snap_ac[1], 8'h00);
    check("W_branch_latency", snap_lat[2], 5);

    // reset asserted during an EXEC wait
    enter_reset(3);
    load(0);
    start_run();
    begin
      int  i;
      bit  found;
      found = 1'b0;
      for (i = 0; i < 100 && !found; i++) begin
        @(negedge clk_i);
        if (n_ret == 1 && mem_req_o && mem_addr_o == 5'd11) found = 1'b1;
      end
      check("R_exec_reached", found, 1);
    end
    check("R_ac_before", ac_o, 8'h7F);
    @(posedge clk_i);
    #2;
    check("R_ac_in_wait", ac_o, 8'h7F);
    chk_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("R_req_drop", mem_req_o, 0);
    check("R_ac_clear", ac_o, 0);
    check("R_pc_clear", pc_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    check("R_ac_held", ac_o, 0);
    check("R_req_held", mem_req_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
